// File: rtl/register_bank_sb.sv
// register_bank_sb: N-read / 1-write register file for the decode stage.
// Register 0 is constant zero. Writes are byte-strobed, can optionally be
// forwarded to matching read ports in the same cycle, and a busy bit per
// register tracks operands still owed by an in-flight producer.
module register_bank_sb #(
  parameter int nb_bits         = 32,
  parameter int nb_bits_address = 5,
  parameter int nb_registres    = 32,
  parameter int nb_read_ports   = 2,
  parameter bit bypass_en       = 1'b1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           write_enable_i,
  input  logic [nb_bits_address-1:0]                     rd_add_i,
  input  logic [nb_bits-1:0]                             rd_data_i,
  input  logic [nb_bits/8-1:0]                           byte_en_i,
  input  logic [nb_read_ports-1:0][nb_bits_address-1:0]  rs_add_i,
  output logic [nb_read_ports-1:0][nb_bits-1:0]          rs_data_o,
  input  logic                                           reserve_i,
  input  logic [nb_bits_address-1:0]                     reserve_add_i,
  input  logic                                           flush_i,
  output logic [nb_read_ports-1:0]                       rs_busy_o,
  output logic                                           any_busy_o
);

  localparam int NB_BYTES = nb_bits / 8;

  // Storage and busy bits exist only for registers 1..nb_registres-1.
  logic [nb_bits-1:0]        r_regs [1:nb_registres-1];
  logic [nb_registres-1:1]   r_busy;

  logic                      w_wr_valid;
  logic                      w_rsv_valid;
  logic [nb_registres-1:1]   w_wr_hit;
  logic [nb_registres-1:1]   w_rsv_hit;
  logic [nb_bits-1:0]        w_wr_old;
  logic [nb_bits-1:0]        w_wr_merged;

  // Address 0 and anything at or beyond nb_registres have no storage.
  function automatic logic addr_in_range(input logic [nb_bits_address-1:0] a);
    return (a != '0) && (32'(a) < 32'(nb_registres));
  endfunction

  // rst_i gates the request qualifiers so bypass is suppressed during reset.
  always_comb begin
    w_wr_valid  = write_enable_i && rst_i && addr_in_range(rd_add_i);
    w_rsv_valid = reserve_i && rst_i && addr_in_range(reserve_add_i);
  end

  // One-hot decode of the write and reserve targets.
  always_comb begin
    w_wr_hit  = '0;
    w_rsv_hit = '0;
    for (int i = 1; i < nb_registres; i++) begin
      w_wr_hit[i]  = w_wr_valid && (rd_add_i == nb_bits_address'(i));
      w_rsv_hit[i] = w_rsv_valid && (reserve_add_i == nb_bits_address'(i));
    end
  end

  // Current contents of the write target, needed for the byte merge.
  always_comb begin
    w_wr_old = '0;
    for (int i = 1; i < nb_registres; i++) begin
      if (rd_add_i == nb_bits_address'(i)) begin
        w_wr_old = r_regs[i];
      end
    end
  end

  // Byte merge: new bytes where the strobe is set, stored bytes elsewhere.
  always_comb begin
    w_wr_merged = '0;
    for (int k = 0; k < NB_BYTES; k++) begin
      w_wr_merged[8*k +: 8] = byte_en_i[k] ? rd_data_i[8*k +: 8] : w_wr_old[8*k +: 8];
    end
  end

  // Register storage; a strobe of all zeros rewrites the old value unchanged.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < nb_registres; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < nb_registres; i++) begin
        if (w_wr_hit[i]) begin
          r_regs[i] <= w_wr_merged;
        end
      end
    end
  end

  // Scoreboard: flush beats reserve, reserve beats the write-back clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_wr_hit) | w_rsv_hit;
    end
  end

  // Read ports: stored data and registered busy, with optional forwarding.
  // Busy is deliberately not forwarded; the hazard unit sees it a cycle later.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int p = 0; p < nb_read_ports; p++) begin
      for (int i = 1; i < nb_registres; i++) begin
        if (rs_add_i[p] == nb_bits_address'(i)) begin
          rs_data_o[p] = r_regs[i];
          rs_busy_o[p] = r_busy[i];
        end
      end
      if (bypass_en && w_wr_valid && (rs_add_i[p] == rd_add_i)) begin
        rs_data_o[p] = w_wr_merged;
      end
    end
  end

  // Summary flag for the hazard unit.
  always_comb begin
    any_busy_o = |r_busy;
  end

endmodule

// File: tb/tb_register_bank_sb.sv
// Directed table-driven bench for register_bank_sb. Two instances share the
// stimulus: one with forwarding, one without, both with 16 registers and
// 3 read ports so range and multi-port behaviour are exercised.
module tb_register_bank_sb;

  logic clk;
  logic rst;
  logic we;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [3:0] be;
  logic [2:0][4:0] rs_add;
  logic rsv;
  logic [4:0] rsa;
  logic fl;

  logic [2:0][31:0] data_b, data_n;
  logic [2:0] busy_b, busy_n;
  logic any_b, any_n;

  int checks = 0;
  int errors = 0;

  register_bank_sb #(.nb_bits(32), .nb_bits_address(5), .nb_registres(16),
                     .nb_read_ports(3), .bypass_en(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .rd_add_i(wa),
    .rd_data_i(wd), .byte_en_i(be), .rs_add_i(rs_add), .rs_data_o(data_b),
    .reserve_i(rsv), .reserve_add_i(rsa), .flush_i(fl),
    .rs_busy_o(busy_b), .any_busy_o(any_b));

  register_bank_sb #(.nb_bits(32), .nb_bits_address(5), .nb_registres(16),
                     .nb_read_ports(3), .bypass_en(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .rd_add_i(wa),
    .rd_data_i(wd), .byte_en_i(be), .rs_add_i(rs_add), .rs_data_o(data_n),
    .reserve_i(rsv), .reserve_add_i(rsa), .flush_i(fl),
    .rs_busy_o(busy_n), .any_busy_o(any_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra0, ra1, ra2;
    logic        rsv;
    logic [4:0]  rsa;
    logic        fl;
    logic [31:0] eb0, eb1, eb2;
    logic [31:0] en0, en1, en2;
    logic [2:0]  busy;
    logic        any;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
      input logic rv, input logic [4:0] ra, input logic f,
      input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
      input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2,
      input logic [2:0] bz, input logic an);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.be = s;
    v.ra0 = r0; v.ra1 = r1; v.ra2 = r2;
    v.rsv = rv; v.rsa = ra; v.fl = f;
    v.eb0 = b0; v.eb1 = b1; v.eb2 = b2;
    v.en0 = n0; v.en1 = n1; v.en2 = n2;
    v.busy = bz; v.any = an;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; be = '0;
    rsv = 1'b0; rsa = '0; fl = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("%s_b_data%0d", tag, p), data_b[p], 32'h0);
      chk($sformatf("%s_n_data%0d", tag, p), data_n[p], 32'h0);
    end
    chk({tag, "_b_busy"}, 32'(busy_b), 32'h0);
    chk({tag, "_n_busy"}, 32'(busy_n), 32'h0);
    chk({tag, "_b_any"}, 32'(any_b), 32'h0);
    chk({tag, "_n_any"}, 32'(any_n), 32'h0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    idle();
    rs_add[0] = 5'd3; rs_add[1] = 5'd7; rs_add[2] = 5'd0;

    //              we wa     wd            be    r0     r1     r2     rsv rsa    fl  bypass-dut data                   no-bypass-dut data                      busy    any
    vecs.push_back(mk(1, 5'd3, 32'h11223344, 4'hF, 5'd3,  5'd3,  5'd0,  0, 5'd0,  0, 32'h11223344, 32'h11223344, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(1, 5'd3, 32'hAABBCCDD, 4'h5, 5'd3,  5'd3,  5'd3,  0, 5'd0,  0, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344, 32'h11223344, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd3,  5'd0,  5'd20, 0, 5'd0,  0, 32'h11BB33DD, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0,  5'd0,  5'd0,  1, 5'd0,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(1, 5'd20,32'h12345678, 4'hF, 5'd20, 5'd3,  5'd0,  1, 5'd20, 0, 32'h0, 32'h11BB33DD, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd20, 5'd4,  5'd3,  0, 5'd0,  0, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h0, 32'h11BB33DD, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd7,  5'd3,  1, 5'd7,  0, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h0, 32'h11BB33DD, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd7,  5'd3,  0, 5'd0,  0, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h0, 32'h11BB33DD, 3'b011, 1));
    vecs.push_back(mk(1, 5'd7, 32'h0000CAFE, 4'hF, 5'd7,  5'd0,  5'd7,  0, 5'd0,  0, 32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h0, 32'h0, 32'h0, 3'b101, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd7,  5'd7,  0, 5'd0,  0, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 3'b000, 0));
    vecs.push_back(mk(1, 5'd7, 32'h12345678, 4'hF, 5'd7,  5'd7,  5'd7,  1, 5'd7,  0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd7,  5'd7,  0, 5'd0,  0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 3'b111, 1));
    vecs.push_back(mk(1, 5'd7, 32'h00000001, 4'h1, 5'd7,  5'd8,  5'd7,  1, 5'd8,  0, 32'h12345601, 32'h0, 32'h12345601, 32'h12345678, 32'h0, 32'h12345678, 3'b101, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd8,  5'd2,  0, 5'd0,  0, 32'h12345601, 32'h0, 32'h0, 32'h12345601, 32'h0, 32'h0, 3'b010, 1));
    vecs.push_back(mk(1, 5'd8, 32'hFFFFFFFF, 4'h0, 5'd8,  5'd8,  5'd8,  0, 5'd0,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b111, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd8,  5'd7,  5'd8,  0, 5'd0,  0, 32'h0, 32'h12345601, 32'h0, 32'h0, 32'h12345601, 32'h0, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd2,  5'd4,  5'd9,  1, 5'd2,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd2,  5'd4,  5'd9,  1, 5'd4,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b001, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd2,  5'd4,  5'd9,  1, 5'd9,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b011, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd2,  5'd4,  5'd9,  1, 5'd10, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b111, 1));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd2,  5'd4,  5'd10, 0, 5'd0,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(1, 5'd12,32'h11111111, 4'hF, 5'd0,  5'd0,  5'd0,  0, 5'd0,  0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(1, 5'd12,32'h0000CAFE, 4'h3, 5'd12, 5'd12, 5'd12, 0, 5'd0,  0, 32'h1111CAFE, 32'h1111CAFE, 32'h1111CAFE, 32'h11111111, 32'h11111111, 32'h11111111, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd12, 5'd12, 5'd12, 0, 5'd0,  0, 32'h1111CAFE, 32'h1111CAFE, 32'h1111CAFE, 32'h1111CAFE, 32'h1111CAFE, 32'h1111CAFE, 3'b000, 0));
    vecs.push_back(mk(1, 5'd15,32'hA5A5A5A5, 4'hF, 5'd15, 5'd16, 5'd15, 1, 5'd16, 0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 3'b000, 0));
    vecs.push_back(mk(0, 5'd0, 32'h0,        4'h0, 5'd15, 5'd16, 5'd15, 0, 5'd0,  0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 3'b000, 0));

    // Reset state, held through a few edges.
    #22;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(negedge clk);
      we = v.we; wa = v.wa; wd = v.wd; be = v.be;
      rs_add[0] = v.ra0; rs_add[1] = v.ra1; rs_add[2] = v.ra2;
      rsv = v.rsv; rsa = v.rsa; fl = v.fl;
      #1;
      chk($sformatf("v%0d_b_data0", i), data_b[0], v.eb0);
      chk($sformatf("v%0d_b_data1", i), data_b[1], v.eb1);
      chk($sformatf("v%0d_b_data2", i), data_b[2], v.eb2);
      chk($sformatf("v%0d_n_data0", i), data_n[0], v.en0);
      chk($sformatf("v%0d_n_data1", i), data_n[1], v.en1);
      chk($sformatf("v%0d_n_data2", i), data_n[2], v.en2);
      chk($sformatf("v%0d_b_busy", i), 32'(busy_b), 32'(v.busy));
      chk($sformatf("v%0d_n_busy", i), 32'(busy_n), 32'(v.busy));
      chk($sformatf("v%0d_b_any", i), 32'(any_b), 32'(v.any));
      chk($sformatf("v%0d_n_any", i), 32'(any_n), 32'(v.any));
    end

    // Mid-run reset: load x5 and mark it busy, then assert reset while a
    // write and reserve are being presented.
    @(negedge clk);
    idle();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; be = 4'hF;
    rsv = 1'b1; rsa = 5'd5;
    rs_add[0] = 5'd5; rs_add[1] = 5'd5; rs_add[2] = 5'd12;
    @(negedge clk);
    idle();
    #1;
    chk("x5_loaded_b", data_b[0], 32'hDEADBEEF);
    chk("x5_loaded_n", data_n[0], 32'hDEADBEEF);
    chk("x5_busy_b", 32'(busy_b), 32'b011);
    chk("x5_any_b", 32'(any_b), 32'h1);

    we = 1'b1; wa = 5'd5; wd = 32'h01010101; be = 4'hF;
    rsv = 1'b1; rsa = 5'd6;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_assert");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    idle();
    rst = 1'b1;
    rs_add[0] = 5'd5; rs_add[1] = 5'd6; rs_add[2] = 5'd12;
    #1;
    chk_all_zero("rst_release");
    @(negedge clk);
    #1;
    chk_all_zero("post_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_sb.md
# register_bank_sb

Parametrised successor to the two-port register bank: an N-read / 1-write register file with per-byte write strobes, optional write-to-read bypass and a per-register busy scoreboard. Register 0 stays hardwired to zero. It sits in the decode stage of the pipelined core. Reads feed the operand path. The scoreboard flags operands still owed by an in-flight instruction so the hazard unit can stall.

## Interface
- nb_bits, 32, data width; must be a multiple of 8
- nb_bits_address, 5, address width
- nb_registres, 32, number of registers; must be ≤ 2**nb_bits_address; register 0 is constant zero
- nb_read_ports, 2, number of independent read ports
- bypass_en, 1, 1 forwards same-cycle write data to matching read ports; 0 makes reads show stored contents only

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous and active-low; clears all state immediately
- write_enable_i  in  1  write request
- rd_add_i  in  nb_bits_address  write address
- rd_data_i  in  nb_bits  write data
- byte_en_i  in  nb_bits/8  write byte strobes; bit k covers bits 8k+7:8k
- rs_add_i  in  nb_read_ports × nb_bits_address  read addresses
- rs_data_o  out  nb_read_ports × nb_bits  read data, combinational
- reserve_i  in  1  mark a register busy (issue of a producer)
- reserve_add_i  in  nb_bits_address  register to mark busy
- flush_i  in  1  synchronous clear of all busy bits
- rs_busy_o  out  nb_read_ports  busy flag of the register addressed by each read port, combinational
- any_busy_o  out  1  OR of all busy bits

## Operation
- Storage covers registers 1..nb_registres-1. Reads of address 0, or of any address ≥ nb_registres, return 0 with busy 0.
- **Write.** Takes effect on a rising edge when write_enable_i=1, rd_add_i is in 1..nb_registres-1 and rst_i=1.
  - Only bytes with byte_en_i[k]=1 are updated; the other bytes keep their value.
  - Writes to address 0 or out of range are ignored.
  - byte_en_i=0 updates no data but still clears busy.
- **Bypass (bypass_en=1).** If a valid write targets the address on port p, rs_data_o[p] shows the byte-merged result in the same cycle.
  - Merged result = new bytes where the strobe is set, stored bytes elsewhere.
  - Every port matching the write address is forwarded independently.
  - Bypass is suppressed while rst_i=0.
- **Scoreboard.** One busy bit per register 1..nb_registres-1. Register 0 is never busy. Precedence per edge, highest first:
  - flush_i=1: all busy bits go to 0. A reserve in the same cycle is also discarded.
  - reserve_i=1 with a valid address: that busy bit goes to 1.
  - Valid write: that busy bit goes to 0.
- A reserve and a write to the same register in the same cycle leaves the register busy, because the new producer wins. The data write still happens.
- A reserve and a write to different registers in the same cycle both take effect.
- rs_busy_o reflects the registered busy bits only. A write in the current cycle does not clear the flag until the next cycle, even when bypass_en=1.

## Timing
- **Reset.** While rst_i=0:
  - all registers read 0; all busy bits are 0;
  - rs_data_o = 0, rs_busy_o = 0, any_busy_o = 0, asynchronously on assertion.
- **Reset release.** The first edge with rst_i=1 may write or reserve.
- **Write latency.**
  - Stored value is visible on rs_data_o in the cycle after the edge.
  - With bypass_en=1, it is visible 0 cycles after presentation, combinationally.
- **Busy latency.** Reserve, clear and flush show on rs_busy_o and any_busy_o one cycle after the edge.
- **Reset mid-operation.** An assertion coincident with write/reserve discards both.
- There is no handshake: every request is accepted in its cycle and there is no back-pressure.

## Test plan
- **Reset.** Assert rst_i low mid-run after writing 0xDEADBEEF to x5 → rs_data_o=0 and all busy flags 0 immediately; reading x5 after release → 0.
- **Byte write.**
  - Write 0x11223344 to x3 with byte_en 1111, then 0xAABBCCDD with byte_en 0101 → x3 reads 0x11BB33DD next cycle.
  - With bypass_en=1, the same merged value appears on the write cycle when rs_add_i[0]=3.
- **x0 and range.** Write 0xFFFFFFFF to x0 and reserve x0 → reads 0, busy 0. With nb_registres=16, write x20 → no register changes and reading x20 returns 0.
- **Scoreboard.**
  - reserve x7 → rs_busy_o=1 next cycle for any port addressing 7, any_busy_o=1.
  - write x7 → busy 0 the following cycle.
  - reserve x7 and write x7 together → x7 updated and busy stays 1.
- **Flush priority.** Reserve x2, x4, x9 over three cycles, then flush_i together with reserve x10 → all busy 0 next cycle, any_busy_o=0.
- **Multi-port bypass.** nb_read_ports=3, all ports addressing x12, write 0x0000CAFE with strobes 0011 → all three ports show the merged value that cycle. With bypass_en=0, they show the old value until the next cycle.
